// File: rtl/lif_pkg.sv
// Shared constants for the leaky integrate-and-fire neuron array.
// Holds the default parameter values and the configuration values that
// reset restores (threshold, leak shift, refractory length).
package lif_pkg;
  localparam int DEF_N      = 4;
  localparam int DEF_W      = 8;
  localparam int DEF_LEAK_W = 3;
  localparam int DEF_REF_W  = 4;

  localparam int RST_THRESHOLD = 8;
  localparam int RST_LEAK      = 1;
  localparam int RST_REFRAC    = 2;
endpackage

// File: rtl/lif_cell.sv
// One LIF neuron channel: leak, saturating integrate, threshold compare,
// and refractory countdown.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   en                integration step strobe
//   current [W]       input current for this channel
//   threshold/leak/refrac  broadcast configuration (registered in the top)
//   state [W]         registered membrane state
//   spike             registered one-cycle spike pulse
//   refrac_active     high while the refractory counter is nonzero
module lif_cell
  import lif_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int LEAK_W = DEF_LEAK_W,
  parameter int REF_W  = DEF_REF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [W-1:0]      current,
  input  logic [W-1:0]      threshold,
  input  logic [LEAK_W-1:0] leak,
  input  logic [REF_W-1:0]  refrac,
  output logic [W-1:0]      state,
  output logic              spike,
  output logic              refrac_active
);
  logic [W-1:0]     leaked;
  logic [W:0]       ns_wide;
  logic [W-1:0]     ns_sat;
  logic             fire;
  logic [REF_W-1:0] cnt;

  assign leaked = (leak == '0) ? '0 : (state >> leak);
  // state - leaked never underflows, so one extra bit catches the add carry.
  assign ns_wide = {1'b0, state} - {1'b0, leaked} + {1'b0, current};
  assign ns_sat  = ns_wide[W] ? '1 : ns_wide[W-1:0];
  assign fire    = (ns_sat >= threshold);
  assign refrac_active = (cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= '0;
      spike <= 1'b0;
      cnt   <= '0;
    end else begin
      spike <= 1'b0;
      if (en) begin
        if (refrac_active) begin
          cnt   <= cnt - REF_W'(1);
          state <= '0;
        end else if (fire) begin
          state <= '0;
          spike <= 1'b1;
          cnt   <= refrac;
        end else begin
          state <= ns_sat;
        end
      end
    end
  end
endmodule

// File: rtl/lif_array.sv
// Array of N independent LIF neuron channels sharing one set of
// configuration registers.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   en                integration step strobe (one step per enabled cycle)
//   current [N*W]     per-channel current, channel i at [i*W +: W]
//   cfg_we            loads cfg_threshold/cfg_leak/cfg_refrac at the edge
//   state [N*W]       registered membrane state, same packing as current
//   spike [N]         registered one-cycle spike pulses
//   refrac_active [N] per-channel refractory flag
module lif_array
  import lif_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int W      = DEF_W,
  parameter int LEAK_W = DEF_LEAK_W,
  parameter int REF_W  = DEF_REF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [N*W-1:0]    current,
  input  logic              cfg_we,
  input  logic [W-1:0]      cfg_threshold,
  input  logic [LEAK_W-1:0] cfg_leak,
  input  logic [REF_W-1:0]  cfg_refrac,
  output logic [N*W-1:0]    state,
  output logic [N-1:0]      spike,
  output logic [N-1:0]      refrac_active
);
  // Cells see only the registered config, so a step coinciding with a
  // write still uses the previous values.
  logic [W-1:0]      thr_q;
  logic [LEAK_W-1:0] leak_q;
  logic [REF_W-1:0]  refrac_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      thr_q    <= W'(RST_THRESHOLD);
      leak_q   <= LEAK_W'(RST_LEAK);
      refrac_q <= REF_W'(RST_REFRAC);
    end else if (cfg_we) begin
      thr_q    <= cfg_threshold;
      leak_q   <= cfg_leak;
      refrac_q <= cfg_refrac;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_cell
    lif_cell #(.W(W), .LEAK_W(LEAK_W), .REF_W(REF_W)) u_cell (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .current       (current[i*W +: W]),
      .threshold     (thr_q),
      .leak          (leak_q),
      .refrac        (refrac_q),
      .state         (state[i*W +: W]),
      .spike         (spike[i]),
      .refrac_active (refrac_active[i])
    );
  end
endmodule

// File: tb/tb_lif_array.sv
module tb_lif_array;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MAXV = 255;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           en = 1'b0;
  logic [N*W-1:0] current = '0;
  logic           cfg_we = 1'b0;
  logic [W-1:0]   cfg_threshold = '0;
  logic [2:0]     cfg_leak = '0;
  logic [3:0]     cfg_refrac = '0;
  logic [N*W-1:0] state;
  logic [N-1:0]   spike;
  logic [N-1:0]   refrac_active;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  lif_array #(.N(N), .W(W), .LEAK_W(3), .REF_W(4)) dut (
    .clk(clk), .reset(reset), .en(en), .current(current),
    .cfg_we(cfg_we), .cfg_threshold(cfg_threshold), .cfg_leak(cfg_leak),
    .cfg_refrac(cfg_refrac), .state(state), .spike(spike),
    .refrac_active(refrac_active)
  );

  always #5 clk = ~clk;

  // Reference model: neuron behaviour in plain integer arithmetic.
  int m_st[N], m_cnt[N], m_spk[N];
  int m_thr = 8, m_lk = 1, m_rf = 2;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin m_st[i] = 0; m_cnt[i] = 0; m_spk[i] = 0; end
      m_thr = 8; m_lk = 1; m_rf = 2;
    end else begin
      for (int i = 0; i < N; i++) begin
        int ns;
        m_spk[i] = 0;
        if (en) begin
          if (m_cnt[i] > 0) begin
            m_cnt[i] = m_cnt[i] - 1;
            m_st[i] = 0;
          end else begin
            ns = m_st[i] - ((m_lk == 0) ? 0 : (m_st[i] >> m_lk)) + int'(current[i*W +: W]);
            if (ns > MAXV) ns = MAXV;
            if (ns >= m_thr) begin
              m_st[i] = 0; m_spk[i] = 1; m_cnt[i] = m_rf;
            end else m_st[i] = ns;
          end
        end
      end
      if (cfg_we) begin
        m_thr = int'(cfg_threshold); m_lk = int'(cfg_leak); m_rf = int'(cfg_refrac);
      end
    end
  end

  // Compare every cycle once the DUT has been reset.
  always @(negedge clk) begin
    if (started) begin
      logic [N*W-1:0] e_st;
      logic [N-1:0]   e_spk, e_act;
      for (int i = 0; i < N; i++) begin
        e_st[i*W +: W] = W'(m_st[i]);
        e_spk[i] = (m_spk[i] != 0);
        e_act[i] = (m_cnt[i] != 0);
      end
      tests = tests + 3;
      if (state !== e_st) begin
        fails++; $display("FAIL model_state t=%0t got=%h exp=%h", $time, state, e_st);
      end
      if (spike !== e_spk) begin
        fails++; $display("FAIL model_spike t=%0t got=%b exp=%b", $time, spike, e_spk);
      end
      if (refrac_active !== e_act) begin
        fails++; $display("FAIL model_refrac t=%0t got=%b exp=%b", $time, refrac_active, e_act);
      end
    end
  end

  function automatic logic [N*W-1:0] cv(input int c0, input int c1, input int c2, input int c3);
    logic [N*W-1:0] v;
    v[0*W +: W] = W'(c0); v[1*W +: W] = W'(c1);
    v[2*W +: W] = W'(c2); v[3*W +: W] = W'(c3);
    return v;
  endfunction

  task automatic tick(input logic e, input logic [N*W-1:0] cur, input logic we,
                      input int th, input int lk, input int rf, input logic rst);
    en = e; current = cur; cfg_we = we; reset = rst;
    cfg_threshold = W'(th); cfg_leak = 3'(lk); cfg_refrac = 4'(rf);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++; $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic int st(input int i);
    return int'(state[i*W +: W]);
  endfunction

  task automatic do_reset();
    tick(1'b0, '0, 1'b0, 0, 0, 0, 1'b1);
  endtask

  task automatic cfg(input int th, input int lk, input int rf);
    tick(1'b0, '0, 1'b1, th, lk, rf, 1'b0);
  endtask

  initial begin
    do_reset();
    started = 1'b1;
    chk("rst_state", int'(state), 0);
    chk("rst_spike", int'(spike), 0);
    chk("rst_refrac", int'(refrac_active), 0);

    // ch0: 3, 6, fire, then repeats
    cfg(8, 0, 0);
    tick(1'b1, cv(3,0,0,0), 1'b0, 0, 0, 0, 1'b0); chk("c30_s1", st(0), 3); chk("c30_p1", int'(spike[0]), 0);
    tick(1'b1, cv(3,0,0,0), 1'b0, 0, 0, 0, 1'b0); chk("c30_s2", st(0), 6);
    tick(1'b1, cv(3,0,0,0), 1'b0, 0, 0, 0, 1'b0); chk("c30_s3", st(0), 0); chk("c30_p3", int'(spike[0]), 1);
    tick(1'b1, cv(3,0,0,0), 1'b0, 0, 0, 0, 1'b0); chk("c30_s4", st(0), 3); chk("c30_p4", int'(spike[0]), 0);

    // ch1 with leak 1: 4, 6, 7, fire
    do_reset(); cfg(8, 1, 0);
    tick(1'b1, cv(0,4,0,0), 1'b0, 0, 0, 0, 1'b0); chk("c31_s1", st(1), 4);
    tick(1'b1, cv(0,4,0,0), 1'b0, 0, 0, 0, 1'b0); chk("c31_s2", st(1), 6);
    tick(1'b1, cv(0,4,0,0), 1'b0, 0, 0, 0, 1'b0); chk("c31_s3", st(1), 7); chk("c31_p3", int'(spike[1]), 0);
    tick(1'b1, cv(0,4,0,0), 1'b0, 0, 0, 0, 1'b0); chk("c31_s4", st(1), 0); chk("c31_p4", int'(spike[1]), 1);

    // ch2 with refractory 2
    do_reset(); cfg(8, 0, 2);
    tick(1'b1, cv(0,0,8,0), 1'b0, 0, 0, 0, 1'b0); chk("c32_p1", int'(spike[2]), 1); chk("c32_a1", int'(refrac_active[2]), 1);
    tick(1'b0, cv(0,0,8,0), 1'b0, 0, 0, 0, 1'b0); chk("c32_hold", int'(refrac_active[2]), 1); chk("c32_en0", int'(spike[2]), 0);
    tick(1'b1, cv(0,0,8,0), 1'b0, 0, 0, 0, 1'b0); chk("c32_a2", int'(refrac_active[2]), 1); chk("c32_s2", st(2), 0);
    tick(1'b1, cv(0,0,8,0), 1'b0, 0, 0, 0, 1'b0); chk("c32_a3", int'(refrac_active[2]), 0); chk("c32_p3", int'(spike[2]), 0);
    tick(1'b1, cv(0,0,8,0), 1'b0, 0, 0, 0, 1'b0); chk("c32_p4", int'(spike[2]), 1);

    // saturation at threshold 255
    do_reset(); cfg(255, 0, 0);
    tick(1'b1, cv(0,0,0,200), 1'b0, 0, 0, 0, 1'b0); chk("c33_s1", st(3), 200); chk("c33_p1", int'(spike[3]), 0);
    tick(1'b1, cv(0,0,0,200), 1'b0, 0, 0, 0, 1'b0); chk("c33_p2", int'(spike[3]), 1); chk("c33_s2", st(3), 0);

    // config write coinciding with a step uses the old threshold
    do_reset(); cfg(8, 0, 0);
    tick(1'b1, cv(5,0,0,0), 1'b1, 4, 0, 0, 1'b0); chk("c34_s1", st(0), 5); chk("c34_p1", int'(spike[0]), 0);
    tick(1'b1, cv(0,0,0,0), 1'b0, 0, 0, 0, 1'b0); chk("c34_p2", int'(spike[0]), 1);

    // reset mid-refractory, then defaults 8/1/2 must be back
    do_reset(); cfg(8, 0, 3);
    tick(1'b1, cv(8,0,0,0), 1'b0, 0, 0, 0, 1'b0); chk("c35_p", int'(spike[0]), 1);
    tick(1'b1, cv(8,0,0,0), 1'b1, 1, 0, 0, 1'b0); chk("c35_a", int'(refrac_active[0]), 1);
    tick(1'b1, cv(8,9,9,9), 1'b1, 1, 0, 0, 1'b1);
    chk("c35_state", int'(state), 0); chk("c35_spike", int'(spike), 0); chk("c35_act", int'(refrac_active), 0);
    tick(1'b1, cv(0,4,0,0), 1'b0, 0, 0, 0, 1'b0); chk("c35_d1", st(1), 4);
    tick(1'b1, cv(0,4,0,0), 1'b0, 0, 0, 0, 1'b0); chk("c35_d2", st(1), 6);
    tick(1'b1, cv(0,4,0,0), 1'b0, 0, 0, 0, 1'b0); chk("c35_d3", st(1), 7);
    tick(1'b1, cv(0,4,0,0), 1'b0, 0, 0, 0, 1'b0); chk("c35_d4", int'(spike[1]), 1);
    tick(1'b1, cv(0,4,0,0), 1'b0, 0, 0, 0, 1'b0); chk("c35_r1", int'(refrac_active[1]), 1);
    tick(1'b1, cv(0,4,0,0), 1'b0, 0, 0, 0, 1'b0); chk("c35_r2", int'(refrac_active[1]), 0);

    // randomized traffic checked by the model
    for (int k = 0; k < 3000; k++) begin
      logic [N*W-1:0] cur;
      int th;
      for (int i = 0; i < N; i++)
        cur[i*W +: W] = ($urandom_range(0, 19) == 0) ? W'($urandom_range(100, 255))
                                                     : W'($urandom_range(0, 30));
      case ($urandom_range(0, 5))
        0: th = 0;
        1: th = 255;
        default: th = $urandom_range(1, 90);
      endcase
      tick($urandom_range(0, 3) != 0, cur, $urandom_range(0, 24) == 0, th,
           $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 149) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lif_array.md
LIF_ARRAY -- requirements
Module: lif_array

Interface
REQ-001 Parameter N, default 4, number of independent neuron channels.
REQ-002 Parameter W, default 8, membrane state and current width per channel (unsigned).
REQ-003 Parameter LEAK_W, default 3, width of the leak shift amount.
REQ-004 Parameter REF_W, default 4, width of the refractory period count.
REQ-005 clk  in  1  single clock; all state updates occur on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 en  in  1  integration step strobe; one step per cycle in which en=1.
REQ-008 current  in  N*W  per-channel input current; channel i occupies bits [i*W +: W].
REQ-009 cfg_we  in  1  configuration write strobe.
REQ-010 cfg_threshold  in  W  firing threshold, shared by all channels.
REQ-011 cfg_leak  in  LEAK_W  leak shift amount; 0 means no leak.
REQ-012 cfg_refrac  in  REF_W  number of refractory steps after a spike.
REQ-013 state  out  N*W  registered membrane state per channel, same packing as current.
REQ-014 spike  out  N  registered one-cycle spike pulse per channel.
REQ-015 refrac_active  out  N  per-channel flag, 1 while that channel's refractory counter is nonzero.

Function
REQ-016 When en=1 and channel i is not refractory, the block SHALL compute NS = state - (cfg_leak==0 ? 0 : state>>cfg_leak) + current in W+1 bits, then saturate it to 2^W-1.
REQ-017 If NS >= threshold, the channel SHALL fire: state<=0, spike[i]<=1, refractory counter<=cfg_refrac. Otherwise state<=NS and spike[i]<=0.
REQ-018 Spike latency SHALL be one cycle: spike[i] is high in the cycle after the qualifying en edge and low in every other cycle.
REQ-019 While refractory (counter>0), each en=1 step SHALL decrement the counter, hold state at 0, ignore current, and keep spike[i]=0.
REQ-020 When en=0, state and refractory counters SHALL hold and spike SHALL be 0.
REQ-021 Threshold 0 SHALL make every non-refractory enabled step fire. cfg_refrac=0 SHALL allow the channel to integrate on the very next step.
REQ-022 cfg_we=1 SHALL load threshold, leak and refrac registers at the clock edge. A step in the same cycle SHALL use the old values, and new values SHALL apply from the next cycle.
REQ-023 A refractory counter already running SHALL NOT be altered by a cfg_we write.
REQ-024 Channels SHALL be fully independent; simultaneous spikes on any subset of channels are legal.

Reset
REQ-025 On reset=1 at a clock edge: all state=0, spike=0, refractory counters=0, refrac_active=0, threshold=8, leak=1, refrac=2.
REQ-026 reset SHALL take priority over en and cfg_we, including mid-refractory and in the same cycle as a firing step.

Structure
REQ-027 Package lif_pkg SHALL hold the reset-default constants (RST_THRESHOLD=8, RST_LEAK=1, RST_REFRAC=2) and the default parameter values.
REQ-028 Sub-module lif_cell SHALL implement one channel (leak, saturating add, compare, refractory counter) and SHALL be instantiated N times via generate.
REQ-029 Configuration registers SHALL reside once in lif_array and be broadcast to all cells.

Verification (N=4, W=8 unless noted)
REQ-030 Config thr=8, leak=0, refrac=0; current ch0=3, en=1 continuously -> state0 goes 3, 6, 0; spike[0] pulses once, in the cycle after the third step; the pattern repeats.
REQ-031 thr=8, leak=1, refrac=0; ch1 current=4 -> state1 goes 4, 6, 7, 0; spike[1] pulses after the 4th step (NS=8).
REQ-032 thr=8, leak=0, refrac=2; ch2 current=8 -> spike after step 1; refrac_active[2]=1 for the next 2 enabled steps with state=0; spike again on step 4.
REQ-033 thr=255, leak=0; ch3 current=200 -> step 1 state=200; step 2 NS saturates to 255, fires and spikes.
REQ-034 cfg_we with thr=4 asserted in the same cycle as a step where state+current=5 under old thr=8 -> no spike on that step; a spike occurs on the next step.
REQ-035 reset asserted mid-refractory with en=1 -> next cycle all state=0, spike=0, refrac_active=0, config back to 8/1/2.
